// File: rtl/fp_minmax_pkg.sv
// Shared types for the streaming floating-point frame min/max stage.
package fp_minmax_pkg;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic nan_seen;
    logic trunc;
  } flags_t;

endpackage

// File: rtl/DW_fp_cmp.sv
// Behavioural stand-in for the DesignWare floating-point comparator, port and
// parameter compatible; link the vendor library model in its place for synthesis.
module DW_fp_cmp #(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic                         zctr,
  output logic                         aeqb,
  output logic                         altb,
  output logic                         agtb,
  output logic                         unordered,
  output logic [sig_width+exp_width:0] z0,
  output logic [sig_width+exp_width:0] z1,
  output logic [7:0]                   status0,
  output logic [7:0]                   status1
);

  localparam int W = sig_width + exp_width + 1;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:sig_width]) && (|x[sig_width-1:0]);
  endfunction

  // Without IEEE compliance, NaNs behave as infinities and denormals as zero.
  function automatic logic is_inf(input logic [W-1:0] x);
    return (&x[W-2:sig_width]) && (~|x[sig_width-1:0] || ieee_compliance == 0);
  endfunction

  function automatic logic is_zero(input logic [W-1:0] x);
    return (~|x[W-2:sig_width]) && (~|x[sig_width-1:0] || ieee_compliance == 0);
  endfunction

  function automatic logic [W-2:0] mag(input logic [W-1:0] x);
    if (is_zero(x)) return '0;
    if (is_inf(x)) return {{exp_width{1'b1}}, {sig_width{1'b0}}};
    return x[W-2:0];
  endfunction

  function automatic logic [7:0] status_of(input logic [W-1:0] x);
    return {5'b0, (ieee_compliance != 0) && is_nan(x), is_inf(x), is_zero(x)};
  endfunction

  logic [W-2:0] ma, mb;
  logic         lt, gt;

  always_comb begin
    ma        = mag(a);
    mb        = mag(b);
    lt        = 1'b0;
    gt        = 1'b0;
    unordered = (ieee_compliance != 0) && (is_nan(a) || is_nan(b));
    // Both magnitudes zero means equal whatever the signs.
    if (!(ma == '0 && mb == '0)) begin
      if (a[W-1] != b[W-1]) begin
        lt = a[W-1];
        gt = b[W-1];
      end else if (!a[W-1]) begin
        lt = ma < mb;
        gt = ma > mb;
      end else begin
        lt = ma > mb;
        gt = ma < mb;
      end
    end
    altb = lt && !unordered;
    agtb = gt && !unordered;
    aeqb = !lt && !gt && !unordered;
    if (agtb ^ zctr) begin
      z0 = b;
      z1 = a;
    end else begin
      z0 = a;
      z1 = b;
    end
    status0 = status_of(z0);
    status1 = status_of(z1);
  end

endmodule

// File: rtl/fp_frame_minmax.sv
// Streaming per-frame min/max reduction of floating-point samples with
// valid/ready on both the sample input and the held per-frame result.
module fp_frame_minmax
  import fp_minmax_pkg::*;
#(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0,
  parameter int idx_width       = 10
) (
  input  logic                         inst_clk,
  input  logic                         inst_rst,
  input  logic                         inst_valid,
  output logic                         inst_ready_o,
  input  logic [sig_width+exp_width:0] inst_data,
  input  logic                         inst_last,
  output logic                         res_valid_inst,
  input  logic                         res_ready,
  output logic [sig_width+exp_width:0] min_inst,
  output logic [sig_width+exp_width:0] max_inst,
  output logic [idx_width-1:0]         min_idx_inst,
  output logic [idx_width-1:0]         max_idx_inst,
  output logic [idx_width:0]           count_inst,
  output logic                         nan_seen_inst,
  output logic                         trunc_inst,
  output state_t                       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid, once raised, holds its payload stable until that edge.

  // The record is sized by this instance's parameters, so it lives here.
  typedef struct packed {
    logic [sig_width+exp_width:0] min;
    logic [sig_width+exp_width:0] max;
    logic [idx_width-1:0]         min_idx;
    logic [idx_width-1:0]         max_idx;
    logic [idx_width:0]           count;
    flags_t                       flags;
  } res_t;

  state_t                       state;
  res_t                         res;
  logic [idx_width:0]           count_nxt;
  logic                         accept;
  logic                         lt_min, unord_min, eq_min, gt_min;
  logic                         lt_max, unord_max, eq_max, gt_max;
  logic [sig_width+exp_width:0] z0_min, z1_min, z0_max, z1_max;
  logic [7:0]                   st0_min, st1_min, st0_max, st1_max;
  logic                         unused_cmp;

  DW_fp_cmp #(
    .sig_width(sig_width), .exp_width(exp_width), .ieee_compliance(ieee_compliance)
  ) u_cmp_min (
    .a(inst_data), .b(res.min), .zctr(1'b0),
    .aeqb(eq_min), .altb(lt_min), .agtb(gt_min), .unordered(unord_min),
    .z0(z0_min), .z1(z1_min), .status0(st0_min), .status1(st1_min)
  );

  DW_fp_cmp #(
    .sig_width(sig_width), .exp_width(exp_width), .ieee_compliance(ieee_compliance)
  ) u_cmp_max (
    .a(inst_data), .b(res.max), .zctr(1'b0),
    .aeqb(eq_max), .altb(lt_max), .agtb(gt_max), .unordered(unord_max),
    .z0(z0_max), .z1(z1_max), .status0(st0_max), .status1(st1_max)
  );

  assign unused_cmp = ^{eq_min, gt_min, eq_max, lt_max, z0_min, z1_min, z0_max,
                        z1_max, st0_min, st1_min, st0_max, st1_max};

  assign accept    = inst_valid && inst_ready_o;
  assign count_nxt = res.count + (idx_width+1)'(1);

  always_ff @(posedge inst_clk) begin
    if (inst_rst) begin
      state <= FIRST;
      res   <= '0;
    end else begin
      case (state)
        FIRST: if (accept) begin
          res.min     <= inst_data;
          res.max     <= inst_data;
          res.min_idx <= '0;
          res.max_idx <= '0;
          res.count   <= (idx_width+1)'(1);
          res.flags   <= '0;
          state       <= inst_last ? HOLD : ACCUM;
        end
        ACCUM: if (accept) begin
          // The new sample's index equals the count before incrementing.
          if (unord_min || unord_max) begin
            res.flags.nan_seen <= 1'b1;
          end else begin
            if (lt_min) begin
              res.min     <= inst_data;
              res.min_idx <= res.count[idx_width-1:0];
            end
            if (gt_max) begin
              res.max     <= inst_data;
              res.max_idx <= res.count[idx_width-1:0];
            end
          end
          res.count <= count_nxt;
          if (inst_last || count_nxt[idx_width]) state <= HOLD;
          if (!inst_last && count_nxt[idx_width]) res.flags.trunc <= 1'b1;
        end
        HOLD: if (res_ready) state <= FIRST;
        default: state <= FIRST;
      endcase
    end
  end

  assign inst_ready_o   = (state != HOLD);
  assign res_valid_inst = (state == HOLD);
  assign min_inst       = res.min;
  assign max_inst       = res.max;
  assign min_idx_inst   = res.min_idx;
  assign max_idx_inst   = res.max_idx;
  assign count_inst     = res.count;
  assign nan_seen_inst  = res.flags.nan_seen;
  assign trunc_inst     = res.flags.trunc;
  assign dbg_state      = state;

endmodule

// File: tb/tb_fp_frame_minmax.sv
// Directed bench for fp_frame_minmax: an IEEE-compliant 10-bit-index instance
// and a non-compliant 2-bit-index instance sharing clock and input stimulus.
module tb_fp_frame_minmax;
  import fp_minmax_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        res_ready = 1'b0;

  logic        ready_a, rv_a, nan_a, trunc_a;
  logic [31:0] min_a, max_a;
  logic [9:0]  min_idx_a, max_idx_a;
  logic [10:0] count_a;
  state_t      dbg_a;

  logic        ready_b, rv_b, nan_b, trunc_b;
  logic [31:0] min_b, max_b;
  logic [1:0]  min_idx_b, max_idx_b;
  logic [2:0]  count_b;
  state_t      dbg_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fp_frame_minmax #(.sig_width(23), .exp_width(8), .ieee_compliance(1), .idx_width(10)) dut_a (
    .inst_clk(clk), .inst_rst(rst), .inst_valid(in_valid), .inst_ready_o(ready_a),
    .inst_data(in_data), .inst_last(in_last), .res_valid_inst(rv_a), .res_ready(res_ready),
    .min_inst(min_a), .max_inst(max_a), .min_idx_inst(min_idx_a), .max_idx_inst(max_idx_a),
    .count_inst(count_a), .nan_seen_inst(nan_a), .trunc_inst(trunc_a), .dbg_state(dbg_a)
  );

  fp_frame_minmax #(.sig_width(23), .exp_width(8), .ieee_compliance(0), .idx_width(2)) dut_b (
    .inst_clk(clk), .inst_rst(rst), .inst_valid(in_valid), .inst_ready_o(ready_b),
    .inst_data(in_data), .inst_last(in_last), .res_valid_inst(rv_b), .res_ready(res_ready),
    .min_inst(min_b), .max_inst(max_b), .min_idx_inst(min_idx_b), .max_idx_inst(max_idx_b),
    .count_inst(count_b), .nan_seen_inst(nan_b), .trunc_inst(trunc_b), .dbg_state(dbg_b)
  );

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [31:0] d, input logic l, input bit sel_b);
    int n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!(sel_b ? ready_b : ready_a) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_vec++; n_miss++;
      $display("FAIL send_timeout: ready stayed low for data %h", d);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handoff();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (ready_a !== 1'b1) begin n_miss++; $display("FAIL rst_ready_a: got %b want 1", ready_a); end
    n_vec++; if (rv_a !== 1'b0) begin n_miss++; $display("FAIL rst_valid_a: got %b want 0", rv_a); end
    n_vec++; if ({min_a, max_a} !== 64'h0) begin n_miss++; $display("FAIL rst_minmax_a: got %h want 0", {min_a, max_a}); end
    n_vec++; if ({min_idx_a, max_idx_a, count_a, nan_a, trunc_a} !== 33'h0) begin n_miss++; $display("FAIL rst_fields_a: got %h want 0", {min_idx_a, max_idx_a, count_a, nan_a, trunc_a}); end
    n_vec++; if (dbg_a !== FIRST) begin n_miss++; $display("FAIL rst_state_a: got %0d want %0d", dbg_a, FIRST); end
    n_vec++; if ({ready_b, rv_b, count_b} !== 5'b10000) begin n_miss++; $display("FAIL rst_b: got %b want 10000", {ready_b, rv_b, count_b}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame();
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b0);
    send(32'hC0400000, 1'b0, 1'b0);
    send(32'h3F800000 >> 1 | 32'h3F000000, 1'b1, 1'b0);
    n_vec++; if (rv_a !== 1'b1) begin n_miss++; $display("FAIL frame_valid: got %b want 1", rv_a); end
    n_vec++; if (ready_a !== 1'b0) begin n_miss++; $display("FAIL frame_ready_low: got %b want 0", ready_a); end
    n_vec++; if (min_a !== 32'hC0400000 || min_idx_a !== 10'd2) begin n_miss++; $display("FAIL frame_min: got %h@%0d want c0400000@2", min_a, min_idx_a); end
    n_vec++; if (max_a !== 32'h40000000 || max_idx_a !== 10'd1) begin n_miss++; $display("FAIL frame_max: got %h@%0d want 40000000@1", max_a, max_idx_a); end
    n_vec++; if (count_a !== 11'd4) begin n_miss++; $display("FAIL frame_count: got %0d want 4", count_a); end
    n_vec++; if ({nan_a, trunc_a} !== 2'b00) begin n_miss++; $display("FAIL frame_flags: got %b want 00", {nan_a, trunc_a}); end
    handoff();
    n_vec++; if ({rv_a, ready_a} !== 2'b01) begin n_miss++; $display("FAIL frame_after_handoff: got %b want 01", {rv_a, ready_a}); end
  endtask

  task automatic test_single();
    n_vec++; if (rv_a !== 1'b0) begin n_miss++; $display("FAIL single_pre_valid: got %b want 0", rv_a); end
    send(32'h3F800000, 1'b1, 1'b0);
    n_vec++; if (rv_a !== 1'b1) begin n_miss++; $display("FAIL single_latency: got %b want 1", rv_a); end
    n_vec++; if (min_a !== 32'h3F800000 || max_a !== 32'h3F800000) begin n_miss++; $display("FAIL single_minmax: got %h/%h want 3f800000/3f800000", min_a, max_a); end
    n_vec++; if ({min_idx_a, max_idx_a} !== 20'h0 || count_a !== 11'd1) begin n_miss++; $display("FAIL single_idx_count: got %0d/%0d/%0d want 0/0/1", min_idx_a, max_idx_a, count_a); end
    handoff();
  endtask

  task automatic test_ties();
    send(32'h40000000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b1, 1'b0);
    n_vec++; if (max_a !== 32'h40000000 || max_idx_a !== 10'd0) begin n_miss++; $display("FAIL ties_max: got %h@%0d want 40000000@0", max_a, max_idx_a); end
    n_vec++; if (min_a !== 32'h3F800000 || min_idx_a !== 10'd2) begin n_miss++; $display("FAIL ties_min: got %h@%0d want 3f800000@2", min_a, min_idx_a); end
    handoff();
  endtask

  task automatic test_nan();
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h7FC00000, 1'b0, 1'b0);
    send(32'h40000000, 1'b1, 1'b0);
    n_vec++; if (nan_a !== 1'b1) begin n_miss++; $display("FAIL nan_seen: got %b want 1", nan_a); end
    n_vec++; if (max_a !== 32'h40000000 || max_idx_a !== 10'd2) begin n_miss++; $display("FAIL nan_max: got %h@%0d want 40000000@2", max_a, max_idx_a); end
    n_vec++; if (min_a !== 32'h3F800000 || min_idx_a !== 10'd0) begin n_miss++; $display("FAIL nan_min: got %h@%0d want 3f800000@0", min_a, min_idx_a); end
    handoff();
  endtask

  task automatic test_signed_zero();
    send(32'h00000000, 1'b0, 1'b0);
    send(32'h80000000, 1'b1, 1'b0);
    n_vec++; if (min_a !== 32'h0 || max_a !== 32'h0) begin n_miss++; $display("FAIL szero_minmax: got %h/%h want 0/0", min_a, max_a); end
    n_vec++; if ({min_idx_a, max_idx_a} !== 20'h0 || count_a !== 11'd2) begin n_miss++; $display("FAIL szero_idx_count: got %0d/%0d/%0d want 0/0/2", min_idx_a, max_idx_a, count_a); end
    handoff();
  endtask

  task automatic test_backpressure();
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b1, 1'b0);
    // Offer a sample while the result is held; it must wait.
    in_data  = 32'hC1000000;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if ({rv_a, ready_a} !== 2'b10) begin n_miss++; $display("FAIL bp_hold_%0d: valid/ready got %b want 10", i, {rv_a, ready_a}); end
      n_vec++; if ({min_a, max_a, count_a} !== {32'h3F800000, 32'h40000000, 11'd2}) begin n_miss++; $display("FAIL bp_stable_%0d: got %h/%h/%0d", i, min_a, max_a, count_a); end
      @(negedge clk);
    end
    handoff();
    n_vec++; if ({rv_a, ready_a} !== 2'b01) begin n_miss++; $display("FAIL bp_release: valid/ready got %b want 01", {rv_a, ready_a}); end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_vec++; if (rv_a !== 1'b1 || min_a !== 32'hC1000000 || count_a !== 11'd1) begin n_miss++; $display("FAIL bp_next_frame: got v%b %h n%0d want v1 c1000000 n1", rv_a, min_a, count_a); end
    handoff();
  endtask

  task automatic test_reset_mid_frame();
    send(32'h40400000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (rv_a !== 1'b0 || count_a !== 11'd0) begin n_miss++; $display("FAIL midrst_cleared: got v%b n%0d want v0 n0", rv_a, count_a); end
    send(32'h40000000, 1'b0, 1'b0);
    send(32'hBF800000, 1'b1, 1'b0);
    n_vec++; if (min_a !== 32'hBF800000 || min_idx_a !== 10'd1) begin n_miss++; $display("FAIL midrst_min: got %h@%0d want bf800000@1", min_a, min_idx_a); end
    n_vec++; if (max_a !== 32'h40000000 || max_idx_a !== 10'd0 || count_a !== 11'd2) begin n_miss++; $display("FAIL midrst_max: got %h@%0d n%0d want 40000000@0 n2", max_a, max_idx_a, count_a); end
    handoff();
  endtask

  task automatic test_trunc();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(32'h3F800000, 1'b0, 1'b1);
    send(32'h40400000, 1'b0, 1'b1);
    send(32'hBF800000, 1'b0, 1'b1);
    send(32'h40000000, 1'b0, 1'b1);
    n_vec++; if (rv_b !== 1'b1 || count_b !== 3'd4 || trunc_b !== 1'b1) begin n_miss++; $display("FAIL trunc_first: got v%b n%0d t%b want v1 n4 t1", rv_b, count_b, trunc_b); end
    n_vec++; if (min_b !== 32'hBF800000 || min_idx_b !== 2'd2 || max_b !== 32'h40400000 || max_idx_b !== 2'd1) begin n_miss++; $display("FAIL trunc_first_vals: got %h@%0d %h@%0d", min_b, min_idx_b, max_b, max_idx_b); end
    handoff();
    send(32'h3F000000, 1'b0, 1'b1);
    send(32'h40800000, 1'b1, 1'b1);
    n_vec++; if (rv_b !== 1'b1 || count_b !== 3'd2 || trunc_b !== 1'b0) begin n_miss++; $display("FAIL trunc_second: got v%b n%0d t%b want v1 n2 t0", rv_b, count_b, trunc_b); end
    n_vec++; if (min_b !== 32'h3F000000 || min_idx_b !== 2'd0 || max_b !== 32'h40800000 || max_idx_b !== 2'd1) begin n_miss++; $display("FAIL trunc_second_vals: got %h@%0d %h@%0d", min_b, min_idx_b, max_b, max_idx_b); end
    handoff();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_single();
    test_ties();
    test_nan();
    test_signed_zero();
    test_backpressure();
    test_reset_mid_frame();
    test_trunc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
